// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : shared timing constants and arbiter state type for the VGA path  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vga_pkg;

   localparam int c_display_height = 480;
   localparam int c_v_total        = 525;
   localparam int c_guard_lines    = 2;

   typedef enum logic [1:0] {
      CLOSED = 2'd0,
      IDLE   = 2'd1,
      GRANT  = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vblank_access_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vblank_access_arbiter_if : request / release / grant bundle of the arbiter |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface vblank_access_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req_in;
   logic [NUM_REQ-1:0] done_in;
   logic [NUM_REQ-1:0] grant_out;

   modport master (output req_in, output done_in, input grant_out);
   modport slave  (input req_in, input done_in, output grant_out);
endinterface
`default_nettype wire

// File: rtl/vblank_access_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, search starts after i_last     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  wire logic [NUM_REQ-1:0] i_req,
   input  wire logic [IDX_W-1:0]   i_last,
   output logic      [NUM_REQ-1:0] o_onehot,
   output logic      [IDX_W-1:0]   o_idx,
   output logic                    o_valid
);

   localparam logic [IDX_W:0] c_num_req = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0] w_cand;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_cand   = '0;
      // Candidate (last + k) mod NUM_REQ; one extra bit avoids overflow before the wrap.
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = {1'b0, i_last} + (IDX_W+1)'(k);
         if (w_cand >= c_num_req) begin
            w_cand = w_cand - c_num_req;
         end
         if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
            o_valid                       = 1'b1;
            o_idx                         = w_cand[IDX_W-1:0];
            o_onehot[w_cand[IDX_W-1:0]]   = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vblank_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vblank_access_arbiter : grants the state-BRAM write port only during       |
// | vertical blanking; frame counter / frame-start pulse. Optional per-window  |
// | grant statistics enabled by macro VBLANK_ARB_STATS_EN.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vblank_access_arbiter
   import vga_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DISPLAY_HEIGHT = c_display_height,
   parameter int V_TOTAL        = c_v_total,
   parameter int GUARD_LINES    = c_guard_lines,
   parameter int MAX_HOLD       = 1024
) (
   input  wire logic               vclock_in,
   input  wire logic               rst_n_in,
   input  wire logic [9:0]         vcount_in,
   vblank_access_arbiter_if.slave  arb,
   output logic                    window_out,
   output logic                    frame_start_out,
   output logic [15:0]             frame_count_out,
   output logic                    overrun_out
`ifdef VBLANK_ARB_STATS_EN
   ,
   output logic [7:0]                   grants_last_frame_out,
   output logic [$clog2(NUM_REQ)-1:0]   busiest_req_out
`endif
);

   localparam int c_idx_w  = $clog2(NUM_REQ);
   localparam int c_hold_w = $clog2(MAX_HOLD);

   localparam logic [9:0]          c_win_open  = 10'(DISPLAY_HEIGHT);
   localparam logic [9:0]          c_win_close = 10'(V_TOTAL - GUARD_LINES);
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);
   localparam logic [c_idx_w-1:0]  c_owner_rst = c_idx_w'(NUM_REQ - 1);

   arb_state_t           r_state;
   arb_state_t           w_state_nxt;
   logic [c_idx_w-1:0]   r_owner;
   logic [c_idx_w-1:0]   w_owner_nxt;
   logic [c_hold_w-1:0]  r_hold;
   logic [c_hold_w-1:0]  w_hold_nxt;
   logic [NUM_REQ-1:0]   r_grant;
   logic [NUM_REQ-1:0]   w_grant_nxt;
   logic                 r_window;
   logic                 r_frame_start;
   logic                 w_frame_start_nxt;
   logic [15:0]          r_frame_count;
   logic                 r_overrun;
   logic                 w_overrun_nxt;
   logic                 w_open;
   logic                 w_close;
   logic                 w_issue;
   logic                 w_window;
   logic                 w_release;

   logic [NUM_REQ-1:0]   w_pick_onehot;
   logic [c_idx_w-1:0]   w_pick_idx;
   logic                 w_pick_valid;

   assign w_window = (vcount_in >= c_win_open) && (vcount_in < c_win_close);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_idx_w)
   ) u_rr_pick (
      .i_req    (arb.req_in),
      .i_last   (r_owner),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

   assign w_release = arb.done_in[r_owner] || !arb.req_in[r_owner] || (r_hold == c_hold_last);

   always_comb begin
      w_state_nxt       = r_state;
      w_owner_nxt       = r_owner;
      w_hold_nxt        = r_hold;
      w_grant_nxt       = r_grant;
      w_frame_start_nxt = 1'b0;
      w_overrun_nxt     = r_overrun;
      w_open            = 1'b0;
      w_close           = 1'b0;
      w_issue           = 1'b0;
      case (r_state)
         CLOSED: begin
            if (w_window) begin
               w_state_nxt       = IDLE;
               w_frame_start_nxt = 1'b1;
               w_open            = 1'b1;
            end
         end
         IDLE: begin
            if (!w_window) begin
               w_state_nxt = CLOSED;
               w_close     = 1'b1;
            end else if (w_pick_valid) begin
               w_state_nxt = GRANT;
               w_grant_nxt = w_pick_onehot;
               w_owner_nxt = w_pick_idx;
               w_hold_nxt  = '0;
               w_issue     = 1'b1;
            end
         end
         GRANT: begin
            // Window closing wins over a same-cycle normal release.
            if (!w_window) begin
               w_state_nxt   = CLOSED;
               w_grant_nxt   = '0;
               w_overrun_nxt = 1'b1;
               w_close       = 1'b1;
            end else if (w_release) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
            end else begin
               w_hold_nxt = r_hold + c_hold_w'(1);
            end
         end
         default: begin
            w_state_nxt = CLOSED;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge vclock_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state       <= CLOSED;
         r_owner       <= c_owner_rst;
         r_hold        <= '0;
         r_grant       <= '0;
         r_window      <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_owner       <= w_owner_nxt;
         r_hold        <= w_hold_nxt;
         r_grant       <= w_grant_nxt;
         r_window      <= (w_state_nxt != CLOSED);
         r_frame_start <= w_frame_start_nxt;
         r_overrun     <= w_overrun_nxt;
         if (w_open) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   assign arb.grant_out       = r_grant;
   assign window_out          = r_window;
   assign frame_start_out     = r_frame_start;
   assign frame_count_out     = r_frame_count;
   assign overrun_out         = r_overrun;

`ifdef VBLANK_ARB_STATS_EN
   logic [7:0]          r_win_grants;
   logic [7:0]          r_req_grants [NUM_REQ];
   logic [7:0]          r_grants_last;
   logic [c_idx_w-1:0]  r_busiest;
   logic [c_idx_w-1:0]  w_busiest;
   logic [7:0]          w_best_cnt;

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      w_busiest  = '0;
      w_best_cnt = r_req_grants[0];
      for (int k = 1; k < NUM_REQ; k++) begin
         if (r_req_grants[k] > w_best_cnt) begin
            w_best_cnt = r_req_grants[k];
            w_busiest  = c_idx_w'(k);
         end
      end
   end

   always_ff @(posedge vclock_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_win_grants  <= '0;
         r_grants_last <= '0;
         r_busiest     <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            r_req_grants[k] <= '0;
         end
      end else begin
         if (w_open) begin
            r_win_grants <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
               r_req_grants[k] <= '0;
            end
         end else if (w_issue) begin
            if (r_win_grants != 8'hFF) begin
               r_win_grants <= r_win_grants + 8'd1;
            end
            if (r_req_grants[w_pick_idx] != 8'hFF) begin
               r_req_grants[w_pick_idx] <= r_req_grants[w_pick_idx] + 8'd1;
            end
         end
         if (w_close) begin
            r_grants_last <= r_win_grants;
            r_busiest     <= w_busiest;
         end
      end
   end

   assign grants_last_frame_out = r_grants_last;
   assign busiest_req_out       = r_busiest;
`endif

endmodule
`default_nettype wire
